// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: load/store controller with lane extract/extend and sub-word read-modify-write.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err.
module dmem_lsu_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [3:0]            req_sign_mask,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
    state_t      state;
    logic        r_we, r_sign;
    logic [2:0]  r_mask;
    logic [1:0]  r_lo;
    logic [31:0] r_wdata;
    logic        req_err;
    logic [31:0] shifted, ld_data, lane_m, lane_d, merged;
    logic        unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
    assign req_ready = state == IDLE;
    always_comb begin
        req_err = !(req_sign_mask[2:0] == 3'b001 || req_sign_mask[2:0] == 3'b011 || req_sign_mask[2:0] == 3'b111);
`ifdef DMEM_MISALIGN_TRAP_EN
        req_err = req_err || (req_sign_mask[2:0] == 3'b011 && req_addr[0])
                          || (req_sign_mask[2:0] == 3'b111 && req_addr[1:0] != 2'b00);
`else
        req_err = req_err || 1'b0;
`endif
        shifted = r_mask == 3'b001 ? mem_rdata >> {r_lo, 3'b000} :
                  r_mask == 3'b011 ? mem_rdata >> {r_lo[1], 4'b0000} : mem_rdata;
        ld_data = r_mask == 3'b001 ? {{24{r_sign & shifted[7]}}, shifted[7:0]} :
                  r_mask == 3'b011 ? {{16{r_sign & shifted[15]}}, shifted[15:0]} : shifted;
        // only sub-word stores reach the merge, so mask is byte or half here
        lane_m  = r_mask == 3'b001 ? 32'h0000_00ff << {r_lo, 3'b000} : 32'h0000_ffff << {r_lo[1], 4'b0000};
        lane_d  = r_mask == 3'b001 ? {4{r_wdata[7:0]}} : {2{r_wdata[15:0]}};
        merged  = (mem_rdata & ~lane_m) | (lane_d & lane_m);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r_we       <= 1'b0;
            r_sign     <= 1'b0;
            r_mask     <= 3'b000;
            r_lo       <= 2'b00;
            r_wdata    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_sign  <= req_sign_mask[3];
                    r_mask  <= req_sign_mask[2:0];
                    r_lo    <= req_addr[1:0];
                    r_wdata <= req_wdata;
                    if (req_err) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        mem_addr <= req_addr[ADDR_WIDTH+1:2];
                        if (req_we && req_sign_mask[2:0] == 3'b111) begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= WAIT;
                WAIT: if (r_we) begin
                    state     <= WR;
                    mem_we    <= 1'b1;
                    mem_wdata <= merged;
                end else begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ld_data;
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: directed vector bench with a registered-read RAM model, plus reset-abort sequence.
module tb_dmem_lsu_ctrl;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [3:0]  req_sign_mask = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;
    logic [31:0] ram [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          we_cnt = 0, rv_cnt = 0;
    int          n_run = 0, n_fail = 0;

    typedef struct {
        logic        we;
        logic [3:0]  sm;
        logic [31:0] addr, wdata;
        logic        pre;
        logic [31:0] init, exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_word;
        int          exp_we;
    } vec_t;
    vec_t v[17];
    vec_t rec;

    dmem_lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_sign_mask(req_sign_mask), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        if (mem_we) we_cnt <= we_cnt + 1;
        if (resp_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic run(input vec_t t, input string nm);
        logic [11:0] w;
        int we0, lat;
        logic [31:0] rd;
        logic er;
        w = t.addr[13:2];
        lat = 0; rd = 'x; er = 1'bx;
        if (t.pre) preload(w, t.init);
        we0 = we_cnt;
        req_valid = 1'b1; req_we = t.we; req_sign_mask = t.sm; req_addr = t.addr; req_wdata = t.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~t.we; req_sign_mask = 4'b0111; req_addr = ~t.addr; req_wdata = ~t.wdata;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({nm, " latency"}, lat, t.exp_lat);
        chk({nm, " rdata"}, rd, t.exp_rdata);
        chk({nm, " err"}, {31'b0, er}, {31'b0, t.exp_err});
        @(posedge clk); #1;
        chk({nm, " pulse"}, {31'b0, resp_valid}, 32'd0);
        chk({nm, " ready"}, {31'b0, req_ready}, 32'd1);
        chk({nm, " ram"}, ram[w], t.exp_word);
        chk({nm, " writes"}, we_cnt - we0, t.exp_we);
    endtask

    initial begin
        int we0, rv0;
        v[0]  = '{1'b0, 4'b1001, 32'h13, 32'h0, 1'b1, 32'h80FF7F01, 32'hFFFFFF80, 1'b0, 3, 32'h80FF7F01, 0};
        v[1]  = '{1'b0, 4'b0011, 32'h12, 32'h0, 1'b0, 32'h0, 32'h000080FF, 1'b0, 3, 32'h80FF7F01, 0};
        v[2]  = '{1'b0, 4'b0001, 32'h10, 32'h0, 1'b0, 32'h0, 32'h00000001, 1'b0, 3, 32'h80FF7F01, 0};
        v[3]  = '{1'b0, 4'b1001, 32'h11, 32'h0, 1'b0, 32'h0, 32'h0000007F, 1'b0, 3, 32'h80FF7F01, 0};
        v[4]  = '{1'b0, 4'b1011, 32'h12, 32'h0, 1'b0, 32'h0, 32'hFFFF80FF, 1'b0, 3, 32'h80FF7F01, 0};
        v[5]  = '{1'b0, 4'b0111, 32'h10, 32'h0, 1'b0, 32'h0, 32'h80FF7F01, 1'b0, 3, 32'h80FF7F01, 0};
        v[6]  = '{1'b1, 4'b0001, 32'h11, 32'hAABBCCDD, 1'b1, 32'h11223344, 32'h0, 1'b0, 4, 32'h1122DD44, 1};
        v[7]  = '{1'b1, 4'b0011, 32'h12, 32'hAABBCCDD, 1'b1, 32'h11223344, 32'h0, 1'b0, 4, 32'hCCDD3344, 1};
        v[8]  = '{1'b1, 4'b0001, 32'h13, 32'hAABBCCDD, 1'b1, 32'h11223344, 32'h0, 1'b0, 4, 32'hDD223344, 1};
        v[9]  = '{1'b1, 4'b0111, 32'h20, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0, 1'b0, 2, 32'hDEADBEEF, 1};
        v[10] = '{1'b0, 4'b0111, 32'h20, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3, 32'hDEADBEEF, 0};
        v[11] = '{1'b0, 4'b0000, 32'h10, 32'h0, 1'b1, 32'h12345678, 32'h0, 1'b1, 1, 32'h12345678, 0};
        v[12] = '{1'b1, 4'b1101, 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b1, 1, 32'h12345678, 0};
        v[13] = '{1'b0, 4'b0111, 32'h22, 32'h0, 1'b1, 32'hCAFEF00D, TRAP ? 32'h0 : 32'hCAFEF00D, TRAP, TRAP ? 1 : 3, 32'hCAFEF00D, 0};
        v[14] = '{1'b0, 4'b0011, 32'h13, 32'h0, 1'b1, 32'h80FF7F01, TRAP ? 32'h0 : 32'h000080FF, TRAP, TRAP ? 1 : 3, 32'h80FF7F01, 0};
        v[15] = '{1'b0, 4'b0111, 32'h4010, 32'h0, 1'b1, 32'h80FF7F01, 32'h80FF7F01, 1'b0, 3, 32'h80FF7F01, 0};
        v[16] = '{1'b1, 4'b1011, 32'h10, 32'h0000BEEF, 1'b1, 32'h11223344, 32'h0, 1'b0, 4, 32'h1122BEEF, 1};
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst mem_addr", {20'b0, mem_addr}, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) run(v[i], $sformatf("v%0d", i));
        // reset while a byte store sits in WAIT must abort without writing
        preload(12'h004, 32'h11223344);
        we0 = we_cnt; rv0 = rv_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_sign_mask = 4'b0001; req_addr = 32'h11; req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort ready", {31'b0, req_ready}, 32'd1);
        chk("abort mem_we", {31'b0, mem_we}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort ram", ram[12'h004], 32'h11223344);
        chk("abort writes", we_cnt - we0, 32'd0);
        chk("abort resp", rv_cnt - rv0, 32'd0);
        @(posedge clk); #1;
        rec = '{1'b0, 4'b0111, 32'h10, 32'h0, 1'b0, 32'h0, 32'h11223344, 1'b0, 3, 32'h11223344, 0};
        run(rec, "recover");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
